// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers with bounded bursts.
// Latency: 1 cycle from accept to registered ack / fifo_wr_en / fifo_data_out.
// Backpressure: never writes when reserved occupancy reaches FIFO_DEPTH; stalls the burst or idles until a read frees space.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    data_in,
  input  logic                             fifo_rd_en,
  output logic [NUM_REQ-1:0]               ack,
  output logic                             fifo_wr_en,
  output logic [DATA_WIDTH-1:0]            fifo_data_out,
  output logic [$clog2(NUM_REQ)-1:0]       grant_id,
  output logic                             busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  count
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH+1);
  localparam int BW  = $clog2(MAX_BURST+1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_ptr, rr_ptr_d;
  logic [BW-1:0]   burst_cnt, burst_cnt_d;
  logic [CW-1:0]   count_d;
  logic [CW-1:0]   occ;
  logic            eff_read;
  logic            space, any_req, cont;
  logic            accept;
  logic [IDW-1:0]  accept_id;
  logic [IDW-1:0]  next_ptr;
  logic [IDW-1:0]  pick_rr, pick_next;
  logic [NUM_REQ-1:0] ack_d;

  // Increment a requester index, wrapping at NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] p);
    if (p == IDW'(NUM_REQ-1)) return '0;
    else return p + IDW'(1);
  endfunction

  // First asserted request at or after 'start', searching in round-robin order.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [IDW-1:0] start);
    logic [IDW-1:0] idx;
    logic [IDW-1:0] sel;
    logic           found;
    idx   = start;
    sel   = start;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && r[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
      idx = inc_wrap(idx);
    end
    return sel;
  endfunction

  // count includes the write still in flight, so space is judged conservatively;
  // a read in this cycle only frees space for the next decision.
  assign space     = (count < CW'(FIFO_DEPTH));
  assign any_req   = |req;
  assign cont      = (state_q == BURST) && req[grant_id] && (burst_cnt < BW'(MAX_BURST));
  assign next_ptr  = inc_wrap(grant_id);
  assign pick_rr   = rr_pick(req, rr_ptr);
  assign pick_next = rr_pick(req, next_ptr);

  // Words actually inside the FIFO exclude the write that lands this cycle.
  assign occ       = count - CW'(fifo_wr_en);
  assign eff_read  = fifo_rd_en && (occ != '0);
  assign count_d   = count + CW'(accept) - CW'(eff_read);

  assign ack_d     = accept ? (NUM_REQ'(1) << accept_id) : '0;
  assign busy      = (state_q == BURST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: stay in BURST while the owner continues (even if stalled) or a handover grant is possible.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (space && any_req) state_d = BURST;
      BURST:   if (!cont && !(space && any_req)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accept decision, burst length and round-robin pointer update.
  always_comb begin
    accept      = 1'b0;
    accept_id   = grant_id;
    burst_cnt_d = burst_cnt;
    rr_ptr_d    = rr_ptr;
    case (state_q)
      IDLE: begin
        if (space && any_req) begin
          accept      = 1'b1;
          accept_id   = pick_rr;
          burst_cnt_d = BW'(1);
        end
      end
      BURST: begin
        if (cont) begin
          if (space) begin
            accept      = 1'b1;
            burst_cnt_d = burst_cnt + BW'(1);
          end
        end else begin
          // Burst over: hand priority to the requester after the owner, regrant without a dead cycle.
          rr_ptr_d = next_ptr;
          if (space && any_req) begin
            accept      = 1'b1;
            accept_id   = pick_next;
            burst_cnt_d = BW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and bookkeeping; reset drops any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr        <= '0;
      burst_cnt     <= '0;
      count         <= '0;
      ack           <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_data_out <= '0;
      grant_id      <= '0;
    end else begin
      rr_ptr     <= rr_ptr_d;
      burst_cnt  <= burst_cnt_d;
      count      <= count_d;
      ack        <= ack_d;
      fifo_wr_en <= accept;
      if (accept) begin
        grant_id      <= accept_id;
        fifo_data_out <= data_in[accept_id*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: reference model predicts per-cycle outputs into a scoreboard queue.
// Latency: expectations pushed at the negedge inputs are driven, checked 1 ns after the next posedge.
// Backpressure: requesters hold each word until the model accepts it.
module tb_fifo_wr_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int MAXB  = 4;
  localparam int WMAX  = 1024;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*DW-1:0]   data_in = '0;
  logic              fifo_rd_en = 1'b0;
  logic [N-1:0]      ack;
  logic              fifo_wr_en;
  logic [DW-1:0]     fifo_data_out;
  logic [1:0]        grant_id;
  logic              busy;
  logic [3:0]        count;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .fifo_rd_en(fifo_rd_en),
    .ack(ack), .fifo_wr_en(fifo_wr_en), .fifo_data_out(fifo_data_out),
    .grant_id(grant_id), .busy(busy), .count(count)
  );

  typedef struct {
    bit          wr;
    int          id;
    logic [15:0] dat;
    int          cnt;
    bit          bsy;
    int          gid;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  int   tally[N];

  logic [DW-1:0] words[N][WMAX];
  int            head[N];
  int            tail[N];

  // Reference model: who owns the port, how long the burst is, where priority starts, reserved words.
  int m_owner, m_len, m_rr, m_count, m_gid;
  bit m_wrote;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_len = 0; m_rr = 0; m_count = 0; m_gid = 0; m_wrote = 1'b0;
  endtask

  task automatic clear_tally();
    for (int k = 0; k < N; k++) tally[k] = 0;
  endtask

  task automatic push_word(input int k, input logic [DW-1:0] w);
    if (tail[k] < WMAX) begin
      words[k][tail[k]] = w;
      tail[k]++;
    end
  endtask

  // One clock of stimulus: drive inputs at the negedge and predict the outcome of the next posedge.
  task automatic cycle(input logic [N-1:0] mask, input bit rd);
    logic [N-1:0] r;
    int   acc;
    int   eff;
    bit   space;
    rec_t e;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      r[k] = mask[k] && (head[k] < tail[k]);
      data_in[k*DW +: DW] = r[k] ? words[k][head[k]] : '0;
    end
    req        = r;
    fifo_rd_en = rd;
    space = (m_count < DEPTH);
    acc   = -1;
    if (m_owner >= 0 && r[m_owner] && m_len < MAXB) begin
      if (space) begin
        acc = m_owner;
        m_len++;
      end
    end else begin
      if (m_owner >= 0) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
      end
      if (space && r != '0)
        for (int i = 0; i < N; i++)
          if (acc < 0 && r[(m_rr + i) % N]) acc = (m_rr + i) % N;
      if (acc >= 0) begin
        m_owner = acc;
        m_len   = 1;
      end
    end
    eff = (rd && (m_count - int'(m_wrote)) > 0) ? 1 : 0;
    e.wr  = (acc >= 0);
    e.id  = acc;
    e.dat = '0;
    if (acc >= 0) begin
      e.dat = words[acc][head[acc]];
      head[acc]++;
      m_gid = acc;
    end
    m_count = m_count + ((acc >= 0) ? 1 : 0) - eff;
    m_wrote = (acc >= 0);
    e.cnt = m_count;
    e.bsy = (m_owner >= 0);
    e.gid = m_gid;
    exp_q.push_back(e);
  endtask

  // Assert reset away from the clock edge, check outputs clear immediately, then release.
  task automatic reset_mid(input bit clr_words);
    @(posedge clk);
    #3;
    mon_en     = 1'b0;
    rst        = 1'b1;
    req        = '0;
    fifo_rd_en = 1'b0;
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_wr_en", fifo_wr_en, 0);
    chk("rst_data", fifo_data_out, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    if (clr_words)
      for (int k = 0; k < N; k++) begin
        head[k] = 0;
        tail[k] = 0;
      end
    mon_en = 1'b1;
  endtask

  // Monitor: every cycle, compare the DUT against the oldest prediction.
  always begin : monitor
    rec_t r;
    @(posedge clk);
    #1;
    if (mon_en && exp_q.size() > 0) begin
      r = exp_q.pop_front();
      chk("wr_en", fifo_wr_en, r.wr);
      if (r.wr) begin
        chk("ack", ack, 64'(1) << r.id);
        chk("data", fifo_data_out, r.dat);
      end else begin
        chk("ack_idle", ack, 0);
      end
      chk("grant_id", grant_id, r.gid);
      chk("count", count, r.cnt);
      chk("busy", busy, r.bsy);
      if (fifo_wr_en)
        for (int k = 0; k < N; k++)
          if (ack[k]) tally[k]++;
    end
  end

  initial begin
    for (int k = 0; k < N; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    model_reset();
    clear_tally();

    // Reset, then a quiet bus must produce no writes.
    reset_mid(1'b1);
    repeat (10) cycle('0, 1'b0);

    // Single requester 2 streams three words then drops its request.
    clear_tally();
    push_word(2, 16'hA001);
    push_word(2, 16'hA002);
    push_word(2, 16'hA003);
    repeat (6) cycle(4'b0100, 1'b0);
    @(posedge clk); #2;
    chk("single_count", count, 3);
    chk("single_busy", busy, 0);
    chk("single_grant", grant_id, 2);
    chk("single_acks", tally[2], 3);

    // Drain, then keep reading on an empty FIFO.
    repeat (6) cycle('0, 1'b1);
    @(posedge clk); #2;
    chk("empty_read_count", count, 0);

    // Read during the write cycle of a lone word cannot consume it yet.
    push_word(0, 16'h1234);
    cycle(4'b0001, 1'b0);
    cycle('0, 1'b1);
    @(posedge clk); #2;
    chk("rd_occ0_count", count, 1);
    repeat (3) cycle('0, 1'b1);

    // All four requesting with no reads: two full bursts fill the FIFO.
    reset_mid(1'b1);
    clear_tally();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 8; j++) push_word(k, 16'((k << 12) | j));
    repeat (14) cycle(4'hF, 1'b0);
    @(posedge clk); #2;
    chk("full_count", count, 8);
    chk("full_ack0", tally[0], 4);
    chk("full_ack1", tally[1], 4);
    chk("full_ack2", tally[2], 0);
    chk("full_busy", busy, 0);

    // One read frees one slot, which goes to requester 2.
    cycle(4'hF, 1'b1);
    repeat (4) cycle(4'hF, 1'b0);
    @(posedge clk); #2;
    chk("refill_count", count, 8);
    chk("refill_ack2", tally[2], 1);

    // Reset in the middle of requester 1's burst, then requesters 1 and 3 compete.
    reset_mid(1'b1);
    for (int j = 0; j < 6; j++) begin
      push_word(1, 16'h1100 + 16'(j));
      push_word(3, 16'h3300 + 16'(j));
    end
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    reset_mid(1'b0);
    clear_tally();
    repeat (12) cycle(4'b1010, 1'b0);
    @(posedge clk); #2;
    chk("mid_rst_ack1", tally[1], 4);
    chk("mid_rst_ack3", tally[3], 4);

    // Randomized traffic with varying read pressure.
    reset_mid(1'b1);
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < N; k++)
        if (head[k] == tail[k] && $urandom_range(0, 2) == 0) begin
          int nw;
          nw = int'($urandom_range(1, 6));
          for (int j = 0; j < nw; j++) push_word(k, 16'($urandom));
        end
      cycle(4'hF, (c < 300) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7));
    end
    repeat (12) cycle('0, 1'b1);
    @(posedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
